// File: rtl/rws_sched_pkg.sv
// Shared types, default parameters and sizing helper for the rws command scheduler.
package rws_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } rws_state_t;

  localparam int NREQ_DEF     = 4;
  localparam int OPW_DEF      = 3;
  localparam int TURN_CYC_DEF = 2;
  localparam int TIMEOUT_DEF  = 15;

  // Bit width needed to index v values; never less than one bit.
  function automatic int clog2_min1(input int v);
    if (v <= 2) begin
      return 1;
    end else begin
      return $clog2(v);
    end
  endfunction

endpackage

// File: rtl/rws_sched_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping modulo NREQ.
module rr_pick
  import rws_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;
  logic          w_hit;

  // Walk candidates in priority order; the wider sum keeps the wrap exact for any NREQ.
  always_comb begin
    gnt     = {NREQ{1'b0}};
    gnt_idx = {IW{1'b0}};
    any     = 1'b0;
    w_sum   = {(IW+1){1'b0}};
    w_idx   = {IW{1'b0}};
    w_hit   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum        = {1'b0, ptr} + (IW+1)'(k);
      w_idx        = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : IW'(w_sum);
      w_hit        = !any && req[w_idx];
      gnt[w_idx]   = gnt[w_idx] | w_hit;
      gnt_idx      = w_hit ? w_idx : gnt_idx;
      any          = any | w_hit;
    end
  end

endmodule

// File: rtl/rws_sched.sv
// Round-robin read/write scheduler: one command in flight, turnaround gap on
// direction change, valid/ready issue and completion-or-timeout wait.
module rws_sched
  import rws_sched_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int OPW      = OPW_DEF,
  parameter int TURN_CYC = TURN_CYC_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  localparam int IW      = clog2_min1(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ*OPW-1:0] req_op,
  output logic [NREQ-1:0]   req_ready,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [OPW-1:0]    cmd_op,
  output logic              cmd_wr,
  output logic [IW-1:0]     cmd_id,
  input  logic              cmd_done,
  output logic [NREQ-1:0]   rsp_done,
  output logic              rsp_err
);

  localparam int CW = clog2_min1(TIMEOUT + 1);
  localparam int TW = clog2_min1(TURN_CYC + 1);

  rws_state_t     r_state;
  rws_state_t     w_state_nxt;
  logic [IW-1:0]  r_rr_ptr;
  logic [IW-1:0]  r_cmd_id;
  logic [OPW-1:0] r_cmd_op;
  logic           r_cmd_wr;
  logic           r_last_vld;
  logic           r_last_wr;
  logic [TW-1:0]  r_turn_cnt;
  logic [CW-1:0]  r_wait_cnt;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_any;
  logic            w_accept;
  logic            w_need_turn;
  logic            w_timeout;
  logic            w_finish;
  logic [IW-1:0]   w_ptr_nxt;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  // Event decode; accept is masked by rst so no grant leaks out while held in reset.
  always_comb begin
    w_accept    = (r_state == IDLE) && w_any && !rst;
    w_need_turn = r_last_vld && (req_wr[w_gnt_idx] != r_last_wr) && (TURN_CYC > 0);
    w_timeout   = (r_state == WAIT) && (r_wait_cnt == CW'(TIMEOUT - 1));
    w_finish    = (r_state == WAIT) && (cmd_done || w_timeout);
    w_ptr_nxt   = (r_cmd_id == IW'(NREQ - 1)) ? {IW{1'b0}} : r_cmd_id + IW'(1);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_need_turn ? TURN : ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      TURN: begin
        if (r_turn_cnt == {TW{1'b0}}) begin
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = TURN;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      WAIT: begin
        if (w_finish) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Command latch, turnaround/timeout counters and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= {IW{1'b0}};
      r_cmd_id   <= {IW{1'b0}};
      r_cmd_op   <= {OPW{1'b0}};
      r_cmd_wr   <= 1'b0;
      r_last_vld <= 1'b0;
      r_last_wr  <= 1'b0;
      r_turn_cnt <= {TW{1'b0}};
      r_wait_cnt <= {CW{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cmd_op   <= req_op[w_gnt_idx*OPW +: OPW];
            r_cmd_wr   <= req_wr[w_gnt_idx];
            r_cmd_id   <= w_gnt_idx;
            r_turn_cnt <= TW'(TURN_CYC - 1);
          end
        end
        TURN: begin
          if (r_turn_cnt != {TW{1'b0}}) begin
            r_turn_cnt <= r_turn_cnt - TW'(1);
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            r_wait_cnt <= {CW{1'b0}};
            r_last_wr  <= r_cmd_wr;
            r_last_vld <= 1'b1;
          end
        end
        WAIT: begin
          // Saturate rather than wrap so a stuck count can never re-arm the timeout.
          if (r_wait_cnt != CW'(TIMEOUT)) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
          if (w_finish) begin
            r_rr_ptr <= w_ptr_nxt;
          end
        end
        default: begin
          r_rr_ptr <= r_rr_ptr;
        end
      endcase
    end
  end

  // Output decode from registered state; completion is visible in the WAIT cycle itself.
  always_comb begin
    req_ready = w_accept ? w_gnt : {NREQ{1'b0}};
    cmd_valid = (r_state == ISSUE);
    cmd_op    = r_cmd_op;
    cmd_wr    = r_cmd_wr;
    cmd_id    = r_cmd_id;
    rsp_done  = w_finish ? ({{(NREQ-1){1'b0}}, 1'b1} << r_cmd_id) : {NREQ{1'b0}};
    rsp_err   = w_finish && !cmd_done;
  end

endmodule

// File: tb/tb_rws_sched.sv
// Directed self-checking bench for rws_sched (NREQ=4 main instance, NREQ=3 wrap instance).
module tb_rws_sched;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  req_valid = 4'b0000;
  logic [3:0]  req_wr    = 4'b0000;
  logic [11:0] req_op    = {3'd4, 3'd3, 3'd2, 3'd1};
  logic [3:0]  req_ready;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [2:0]  cmd_op;
  logic        cmd_wr;
  logic [1:0]  cmd_id;
  logic        cmd_done  = 1'b0;
  logic [3:0]  rsp_done;
  logic        rsp_err;

  logic [2:0]  req_valid3 = 3'b000;
  logic [2:0]  req_wr3    = 3'b000;
  logic [8:0]  req_op3    = {3'd6, 3'd5, 3'd4};
  logic [2:0]  req_ready3;
  logic        cmd_valid3;
  logic        cmd_ready3 = 1'b0;
  logic [2:0]  cmd_op3;
  logic        cmd_wr3;
  logic [1:0]  cmd_id3;
  logic        cmd_done3  = 1'b0;
  logic [2:0]  rsp_done3;
  logic        rsp_err3;

  int n_total = 0;
  int n_bad   = 0;
  int n_rdy3  = 0;
  int n_rsp3  = 0;

  always #5 clk = ~clk;

  rws_sched #(.NREQ(4), .OPW(3), .TURN_CYC(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_op(req_op),
    .req_ready(req_ready), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wr(cmd_wr), .cmd_id(cmd_id), .cmd_done(cmd_done), .rsp_done(rsp_done), .rsp_err(rsp_err)
  );

  rws_sched #(.NREQ(3), .OPW(3), .TURN_CYC(2), .TIMEOUT(TMO)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_wr(req_wr3), .req_op(req_op3),
    .req_ready(req_ready3), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op3),
    .cmd_wr(cmd_wr3), .cmd_id(cmd_id3), .cmd_done(cmd_done3), .rsp_done(rsp_done3), .rsp_err(rsp_err3)
  );

  // Pulse counters for the wrap instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (req_ready3 != 3'b000) n_rdy3 <= n_rdy3 + 1;
    if (rsp_done3 != 3'b000)  n_rsp3 <= n_rsp3 + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One command on the NREQ=4 instance; caller has set req_* in the IDLE cycle.
  task automatic run_cmd(input int id, input int op, input int wr, input int turn,
                         input int stall, input int done_at);
    int ev;
    ev = (done_at < TMO - 1) ? done_at : TMO - 1;
    #1;
    chk_eq("accept_rdy", 32'(req_ready), 32'd1 << id);
    chk_eq("accept_vld", 32'(cmd_valid), 32'd0);
    tick;
    for (int t = 0; t < turn; t++) begin
      #1;
      chk_eq("turn_vld", 32'(cmd_valid), 32'd0);
      chk_eq("turn_rdy", 32'(req_ready), 32'd0);
      tick;
    end
    for (int s = 0; s < stall; s++) begin
      cmd_ready = 1'b0;
      cmd_done  = 1'b1;
      #1;
      chk_eq("stall_vld", 32'(cmd_valid), 32'd1);
      chk_eq("stall_id",  32'(cmd_id), 32'(id));
      chk_eq("stall_op",  32'(cmd_op), 32'(op));
      chk_eq("stall_rdy", 32'(req_ready), 32'd0);
      tick;
    end
    cmd_ready = 1'b1;
    cmd_done  = 1'b0;
    #1;
    chk_eq("issue_vld", 32'(cmd_valid), 32'd1);
    chk_eq("issue_id",  32'(cmd_id), 32'(id));
    chk_eq("issue_op",  32'(cmd_op), 32'(op));
    chk_eq("issue_wr",  32'(cmd_wr), 32'(wr));
    tick;
    cmd_ready = 1'b0;
    for (int w = 0; w <= ev; w++) begin
      cmd_done = (w == done_at);
      #1;
      chk_eq("wait_rsp", 32'(rsp_done), (w == ev) ? (32'd1 << id) : 32'd0);
      chk_eq("wait_err", 32'(rsp_err), ((w == ev) && (done_at != ev)) ? 32'd1 : 32'd0);
      tick;
    end
    cmd_done = 1'b0;
  endtask

  initial begin
    tick;
    req_valid = 4'b0101;
    #1;
    chk_eq("rst_rdy", 32'(req_ready), 32'd0);
    chk_eq("rst_vld", 32'(cmd_valid), 32'd0);
    chk_eq("rst_op",  32'(cmd_op), 32'd0);
    chk_eq("rst_wr",  32'(cmd_wr), 32'd0);
    chk_eq("rst_id",  32'(cmd_id), 32'd0);
    chk_eq("rst_rsp", 32'(rsp_done), 32'd0);
    chk_eq("rst_err", 32'(rsp_err), 32'd0);
    chk_eq("rst_vld3", 32'(cmd_valid3), 32'd0);
    tick;
    rst = 1'b0;

    // Alternating grants between requesters 0 and 2, reads, immediate completion.
    req_valid = 4'b0101;
    req_wr    = 4'b0000;
    run_cmd(0, 1, 0, 0, 0, 0);
    run_cmd(2, 3, 0, 0, 0, 0);
    run_cmd(0, 1, 0, 0, 0, 0);
    run_cmd(2, 3, 0, 0, 0, 0);

    // Read then write (turnaround of 2), then write to write with no gap.
    req_valid = 4'b0001; req_wr = 4'b0000;
    run_cmd(0, 1, 0, 0, 0, 0);
    req_valid = 4'b0010; req_wr = 4'b0010;
    run_cmd(1, 2, 1, 2, 0, 0);
    req_valid = 4'b0100; req_wr = 4'b0100;
    run_cmd(2, 3, 1, 0, 0, 0);

    // Issue stalled 5 cycles with stray cmd_done that must be ignored.
    req_valid = 4'b1000; req_wr = 4'b1000;
    run_cmd(3, 4, 1, 0, 5, 2);

    // Timeout, then completion on the exact timeout cycle.
    req_valid = 4'b0010; req_wr = 4'b0010;
    run_cmd(1, 2, 1, 0, 0, 99);
    req_valid = 4'b0100; req_wr = 4'b0100;
    run_cmd(2, 3, 1, 0, 0, TMO - 1);

    // Reset during WAIT of a read that followed writes.
    req_valid = 4'b0011; req_wr = 4'b0000;
    #1;
    chk_eq("r5_rdy", 32'(req_ready), 32'd1);
    tick; tick; tick;
    cmd_ready = 1'b1;
    #1;
    chk_eq("r5_vld", 32'(cmd_valid), 32'd1);
    tick;
    cmd_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk_eq("r5_rst_vld", 32'(cmd_valid), 32'd0);
    chk_eq("r5_rst_op",  32'(cmd_op), 32'd0);
    chk_eq("r5_rst_rsp", 32'(rsp_done), 32'd0);
    chk_eq("r5_rst_rdy", 32'(req_ready), 32'd0);
    tick;
    rst = 1'b0;
    req_valid = 4'b0110; req_wr = 4'b0110;
    run_cmd(1, 2, 1, 0, 0, 0);
    req_valid = 4'b0000;

    // NREQ=3 wrap: 0,1,2,0.
    req_valid3 = 3'b111;
    req_wr3    = 3'b000;
    cmd_ready3 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      int e;
      e = g % 3;
      #1;
      chk_eq("n3_rdy", 32'(req_ready3), 32'd1 << e);
      tick;
      #1;
      chk_eq("n3_id", 32'(cmd_id3), 32'(e));
      chk_eq("n3_op", 32'(cmd_op3), 32'(4 + e));
      tick;
      cmd_done3 = 1'b1;
      #1;
      chk_eq("n3_rsp", 32'(rsp_done3), 32'd1 << e);
      tick;
      cmd_done3 = 1'b0;
      if (g == 3) req_valid3 = 3'b000;
    end
    tick; tick;
    chk_eq("n3_rdy_cnt", 32'(n_rdy3), 32'd4);
    chk_eq("n3_rsp_cnt", 32'(n_rsp3), 32'd4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
